// File: rtl/load_accum_mc.sv
// Multi-channel signed multiply-accumulate: P[ch] = P[ch] +/- A*B, time-interleaved
// on one multiplier, with per-op clear, guard bits and optional saturation.
module load_accum_mc #(
  parameter  int A_W      = 20,
  parameter  int B_W      = 18,
  parameter  int GUARD_W  = 4,
  parameter  int NUM_CH   = 4,
  parameter  int SATURATE = 1,
  localparam int ACC_W    = A_W + B_W + GUARD_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic              subtract_i,
  input  logic              load_acc_i,
  input  logic              clear_i,
  input  logic [A_W-1:0]    A,
  input  logic [B_W-1:0]    B,
  output logic [ACC_W-1:0]  P,
  output logic              valid_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              ovf_o,
  output logic [NUM_CH-1:0] ovf_sticky_o
);

  localparam int PROD_W = A_W + B_W;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

  // stage 1: registered inputs
  logic                     v1, sub1, ld1, clr1;
  logic [CH_W-1:0]          ch1;
  logic signed [A_W-1:0]    a1;
  logic signed [B_W-1:0]    b1;
  // stage 2: raw product, then a second register so the multiplier keeps its output register
  logic                     v2, sub2, ld2, clr2;
  logic [CH_W-1:0]          ch2;
  logic signed [PROD_W-1:0] prod2;
  logic                     v3, sub3, ld3, clr3;
  logic [CH_W-1:0]          ch3;
  logic signed [ACC_W-1:0]  prod3;
  // stage 3: accumulator bank, read-modify-write in one place only
  logic signed [ACC_W-1:0]  acc [NUM_CH];

  logic signed [ACC_W-1:0]  acc_rd;
  logic signed [ACC_W:0]    base, addend, sum;
  logic                     do_write, ovf;
  logic signed [ACC_W-1:0]  result;

  always_comb begin
    acc_rd   = acc[ch3];
    do_write = v3 & (clr3 | ld3);
    base     = clr3 ? '0 : (ACC_W + 1)'(acc_rd);
    addend   = (ACC_W + 1)'(prod3);
    sum      = sub3 ? (base - addend) : (base + addend);
    ovf      = do_write & (sum[ACC_W] ^ sum[ACC_W-1]);
    if (!do_write)
      result = acc_rd;
    else if (ovf && SATURATE != 0)
      result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      result = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; sub1 <= 1'b0; ld1 <= 1'b0; clr1 <= 1'b0;
      ch1 <= '0; a1 <= '0; b1 <= '0;
      v2 <= 1'b0; sub2 <= 1'b0; ld2 <= 1'b0; clr2 <= 1'b0;
      ch2 <= '0; prod2 <= '0;
      v3 <= 1'b0; sub3 <= 1'b0; ld3 <= 1'b0; clr3 <= 1'b0;
      ch3 <= '0; prod3 <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      ovf_sticky_o <= '0;
      P       <= '0;
      valid_o <= 1'b0;
      ch_o    <= '0;
      ovf_o   <= 1'b0;
    end else begin
      // out-of-range channels are dropped here so later stages never see them
      v1   <= valid_i & ({1'b0, ch_i} < CH_LIMIT);
      sub1 <= subtract_i;
      ld1  <= load_acc_i;
      clr1 <= clear_i;
      ch1  <= ch_i;
      a1   <= A;
      b1   <= B;

      v2    <= v1;
      sub2  <= sub1;
      ld2   <= ld1;
      clr2  <= clr1;
      ch2   <= ch1;
      prod2 <= PROD_W'(a1) * PROD_W'(b1);

      v3    <= v2;
      sub3  <= sub2;
      ld3   <= ld2;
      clr3  <= clr2;
      ch3   <= ch2;
      prod3 <= ACC_W'(prod2);

      if (do_write) begin
        acc[ch3] <= result;
        if (clr3)
          ovf_sticky_o[ch3] <= 1'b0;
        else if (ovf)
          ovf_sticky_o[ch3] <= 1'b1;
      end

      valid_o <= v3;
      ovf_o   <= ovf;
      if (v3) begin
        P    <= result;
        ch_o <= ch3;
      end
    end
  end

endmodule

// File: tb/tb_load_accum_mc.sv
// Bench for load_accum_mc: saturating and wrapping instances share stimulus; a
// three-channel instance checks that out-of-range channels are dropped.
module tb_load_accum_mc;

  localparam longint MAXV  = (longint'(1) << 41) - 1;
  localparam longint MINV  = -(longint'(1) << 41);
  localparam longint TWO42 = longint'(1) << 42;
  localparam longint P36   = longint'(1) << 36;
  localparam longint AMIN  = -(longint'(1) << 19);
  localparam longint BMIN  = -(longint'(1) << 17);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i = 1'b0, subtract_i = 1'b0, load_acc_i = 1'b0, clear_i = 1'b0;
  logic [1:0]  ch_i = '0;
  logic [19:0] a_i = '0;
  logic [17:0] b_i = '0;

  logic signed [41:0] p_s, p_w, p_3;
  logic               valid_s, valid_w, valid_3, ovf_s, ovf_w, ovf_3;
  logic [1:0]         ch_s, ch_w, ch_3;
  logic [3:0]         stk_s, stk_w;
  logic [2:0]         stk_3;

  load_accum_mc #(.SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ch_i(ch_i), .subtract_i(subtract_i),
    .load_acc_i(load_acc_i), .clear_i(clear_i), .A(a_i), .B(b_i), .P(p_s),
    .valid_o(valid_s), .ch_o(ch_s), .ovf_o(ovf_s), .ovf_sticky_o(stk_s));

  load_accum_mc #(.SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ch_i(ch_i), .subtract_i(subtract_i),
    .load_acc_i(load_acc_i), .clear_i(clear_i), .A(a_i), .B(b_i), .P(p_w),
    .valid_o(valid_w), .ch_o(ch_w), .ovf_o(ovf_w), .ovf_sticky_o(stk_w));

  load_accum_mc #(.NUM_CH(3), .SATURATE(1)) dut_3 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ch_i(ch_i), .subtract_i(subtract_i),
    .load_acc_i(load_acc_i), .clear_i(clear_i), .A(a_i), .B(b_i), .P(p_3),
    .valid_o(valid_3), .ch_o(ch_3), .ovf_o(ovf_3), .ovf_sticky_o(stk_3));

  typedef struct {
    logic v; logic [1:0] ch; logic sub; logic ld; logic clr;
    longint a; longint b;
    logic chk; logic ev; logic [1:0] ech;
    longint ep_s; longint ep_w;
    logic eovf_s; logic eovf_w;
    logic [3:0] estk_s; logic [3:0] estk_w;
  } vec_t;

  vec_t pend[$];
  vec_t tbl[22];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(logic v, logic [1:0] ch, logic sub, logic ld, logic clr,
                              longint a, longint b, longint ep);
    vec_t x;
    x.v = v; x.ch = ch; x.sub = sub; x.ld = ld; x.clr = clr; x.a = a; x.b = b;
    x.chk = 1'b1; x.ev = v; x.ech = ch; x.ep_s = ep; x.ep_w = ep;
    x.eovf_s = 1'b0; x.eovf_w = 1'b0; x.estk_s = '0; x.estk_w = '0;
    return x;
  endfunction

  function automatic vec_t idle_v();
    vec_t x;
    x = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    x.chk = 1'b0;
    return x;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic check_vec(vec_t e);
    if (!e.chk) return;
    chk("valid_sat", valid_s, e.ev);
    chk("valid_wrap", valid_w, e.ev);
    chk("p_sat", p_s, e.ep_s);
    chk("p_wrap", p_w, e.ep_w);
    chk("ch_sat", ch_s, e.ech);
    chk("ch_wrap", ch_w, e.ech);
    chk("ovf_sat", ovf_s, e.eovf_s);
    chk("ovf_wrap", ovf_w, e.eovf_w);
    chk("sticky_sat", stk_s, e.estk_s);
    chk("sticky_wrap", stk_w, e.estk_w);
    $display("txn valid=%0d ch=%0d P_sat=%0d P_wrap=%0d ovf=%0d/%0d sticky=%b/%b",
             valid_s, ch_s, p_s, p_w, ovf_s, ovf_w, stk_s, stk_w);
  endtask

  // one cycle: check the op issued four negedges ago, then drive the next op
  task automatic tick(vec_t x);
    vec_t h;
    @(negedge clk);
    if (pend.size() >= 4) begin
      h = pend.pop_front();
      check_vec(h);
    end
    valid_i = x.v; ch_i = x.ch; subtract_i = x.sub; load_acc_i = x.ld; clear_i = x.clr;
    a_i = 20'(x.a); b_i = 18'(x.b);
    pend.push_back(x);
  endtask

  task automatic drain();
    repeat (4) tick(idle_v());
  endtask

  task automatic sat_seq(logic [1:0] ch, logic [3:0] stk);
    vec_t x;
    tick(mk(1'b1, ch, 1'b0, 1'b1, 1'b1, AMIN, BMIN, P36));
    for (int k = 2; k <= 31; k++)
      tick(mk(1'b1, ch, 1'b0, 1'b1, 1'b0, AMIN, BMIN, longint'(k) * P36));
    x = mk(1'b1, ch, 1'b0, 1'b1, 1'b0, AMIN, BMIN, 0);
    x.ep_s = MAXV; x.ep_w = MINV; x.eovf_s = 1'b1; x.eovf_w = 1'b1;
    x.estk_s = stk; x.estk_w = stk;
    tick(x);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b0; valid_i = 1'b0;
    pend.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  function automatic void step(input logic sat, inout longint acc, inout logic stk,
                               input vec_t x, output longint res, output logic ov);
    longint p, n;
    p = x.a * x.b;
    if (!x.clr && !x.ld) begin
      res = acc; ov = 1'b0;
      return;
    end
    n  = (x.clr ? 0 : acc) + (x.sub ? -p : p);
    ov = (n > MAXV) || (n < MINV);
    if (!ov)      res = n;
    else if (sat) res = (n > MAXV) ? MAXV : MINV;
    else          res = (n > MAXV) ? n - TWO42 : n + TWO42;
    acc = res;
    if (x.clr)   stk = 1'b0;
    else if (ov) stk = 1'b1;
  endfunction

  initial begin
    vec_t   x;
    longint ms[4], mw[4], lps, lpw, rs, rw, ta;
    logic [3:0] ks, kw;
    logic [1:0] lch;
    logic   tk, os, ow;
    int     r;

    tbl[0]  = mk(1, 0, 0, 1, 0, 5, 2, 10);
    tbl[1]  = mk(1, 1, 0, 1, 1, 5, 2, 10);
    tbl[2]  = mk(1, 1, 0, 1, 0, 3, -4, -2);
    tbl[3]  = mk(1, 1, 1, 1, 0, 7, 6, -44);
    tbl[4]  = mk(1, 0, 0, 1, 1, 1, 10, 10);
    tbl[5]  = mk(1, 1, 0, 1, 1, 2, 10, 20);
    tbl[6]  = mk(1, 2, 0, 1, 1, 3, 10, 30);
    tbl[7]  = mk(1, 3, 0, 1, 1, 4, 10, 40);
    tbl[8]  = mk(1, 0, 0, 1, 0, 1, 1, 11);
    tbl[9]  = mk(1, 1, 0, 1, 0, 1, 1, 21);
    tbl[10] = mk(1, 2, 0, 1, 0, 1, 1, 31);
    tbl[11] = mk(1, 3, 0, 1, 0, 1, 1, 41);
    tbl[12] = mk(1, 2, 0, 0, 0, 123, -77, 31);
    tbl[13] = mk(0, 2, 0, 1, 0, 8, 8, 31);
    tbl[14] = mk(0, 2, 1, 1, 1, 9, 9, 31);
    tbl[15] = mk(1, 3, 1, 1, 1, 4, 5, -20);
    tbl[16] = mk(1, 0, 1, 0, 0, 9, 9, 11);
    tbl[17] = mk(1, 0, 0, 0, 1, -3, 3, -9);
    tbl[18] = mk(1, 0, 1, 1, 0, -2, -8, -25);
    tbl[19] = mk(1, 1, 0, 1, 0, -6, -7, 63);
    tbl[20] = mk(0, 1, 0, 1, 1, 100, 100, 63);
    tbl[21] = mk(1, 1, 0, 0, 0, 1, 1, 63);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p", p_s, 0);
    chk("rst_valid", valid_s, 0);
    chk("rst_sticky", stk_s, 0);
    #1 reset = 1'b1;

    for (int i = 0; i < 22; i++) tick(tbl[i]);
    drain();

    // a channel beyond NUM_CH is ignored by the three-channel instance
    tick(mk(1, 2, 0, 0, 0, 5, 5, 31));
    tick(mk(1, 3, 0, 1, 1, 1, 1, 1));
    drain();
    chk("ch_oob_valid", valid_3, 0);
    chk("ch_oob_p", p_3, 31);
    chk("ch_oob_ch", ch_3, 2);
    chk("ch_oob_sticky", stk_3, 0);

    // saturation / wrap at 2^41, then clear resets sticky
    sat_seq(2'd0, 4'b0001);
    tick(mk(1, 0, 0, 1, 1, 1, 1, 1));
    sat_seq(2'd1, 4'b0010);
    drain();

    // asynchronous reset with ops in flight
    for (int i = 0; i < 4; i++) tick(mk(1, 1, 0, 1, 0, 3, 3, 0));
    @(posedge clk); #2;
    reset = 1'b0; valid_i = 1'b0;
    #1;
    chk("arst_p_sat", p_s, 0);
    chk("arst_p_wrap", p_w, 0);
    chk("arst_valid", valid_s, 0);
    chk("arst_sticky_sat", stk_s, 0);
    chk("arst_sticky_wrap", stk_w, 0);
    chk("arst_ch", ch_s, 0);
    pend.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick(mk(1, 0, 0, 1, 0, 5, 2, 10));
    for (int i = 0; i < 3; i++) begin
      tick(idle_v());
      chk("discard_valid", valid_s, 0);
      chk("discard_p", p_s, 0);
    end
    tick(mk(1, 1, 0, 0, 0, 9, 9, 0));
    drain();

    // random ops against a reference model
    pulse_reset();
    for (int c = 0; c < 4; c++) begin ms[c] = 0; mw[c] = 0; end
    ks = '0; kw = '0; lps = 0; lpw = 0; lch = '0;
    for (int i = 0; i < 1000; i++) begin
      x = idle_v();
      x.chk = 1'b1;
      x.v   = ($urandom_range(0, 9) != 0);
      x.ch  = 2'($urandom_range(0, 3));
      r     = int'($urandom_range(0, 63));
      x.clr = (r == 0);
      x.ld  = !(r >= 1 && r <= 6);
      x.sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        x.a = AMIN; x.b = BMIN; x.sub = x.ch[1];
      end else begin
        x.a = longint'($urandom_range(0, (1 << 20) - 1)) - (longint'(1) << 19);
        x.b = longint'($urandom_range(0, (1 << 18) - 1)) - (longint'(1) << 17);
      end
      x.ev = x.v;
      if (x.v) begin
        ta = ms[x.ch]; tk = ks[x.ch];
        step(1'b1, ta, tk, x, rs, os);
        ms[x.ch] = ta; ks[x.ch] = tk;
        ta = mw[x.ch]; tk = kw[x.ch];
        step(1'b0, ta, tk, x, rw, ow);
        mw[x.ch] = ta; kw[x.ch] = tk;
        lps = rs; lpw = rw; lch = x.ch;
        x.eovf_s = os; x.eovf_w = ow;
      end
      x.ep_s = lps; x.ep_w = lpw; x.ech = lch;
      x.estk_s = ks; x.estk_w = kw;
      tick(x);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
